// File: rtl/serial_frame_pkg.sv
// Shared types and line levels for the serial frame transmitter.
package serial_frame_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      GAP    = 3'd4
   } tx_state_e;

   localparam logic IDLE_LEVEL  = 1'b0;
   localparam logic START_LEVEL = 1'b1;

endpackage

// File: rtl/serial_frame_tx_bit_tick_gen.sv
// Bit-time divider: tick is high on the last clock cycle of every bit time.
module bit_tick_gen #(
   parameter int CLKS_PER_BIT = 1
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int TW = $clog2(CLKS_PER_BIT + 1);
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] cnt_q;
   logic [TW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear || (cnt_q == LAST)) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = (cnt_q == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional
// even parity, idle-low gap, all on a registered single-bit line.
module serial_frame_tx
   import serial_frame_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int PARITY_EN    = 1,
   parameter int GAP_BITS     = 1,
   parameter int CNT_W        = 16
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic              tx_ready,
   output logic              ser_out,
   output logic              ser_frame,
   output logic              busy,
   output logic [CNT_W-1:0]  frames_sent,
   output logic [2:0]        state_dbg_o
);

   localparam int BIT_W = $clog2(DATA_W + 1);
   localparam int GAP_W = $clog2(GAP_BITS + 1);
   localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'(GAP_BITS - 1);

   if (CLKS_PER_BIT < 1) begin : g_bad_clks
      $error("serial_frame_tx: CLKS_PER_BIT must be >= 1");
   end
   if (GAP_BITS < 1) begin : g_bad_gap
      $error("serial_frame_tx: GAP_BITS must be >= 1");
   end
   if ((DATA_W < 1) || (DATA_W > 32)) begin : g_bad_width
      $error("serial_frame_tx: DATA_W must be in 1..32");
   end

   tx_state_e         state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic              parity_q, parity_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
   logic [CNT_W-1:0]  frames_q, frames_d;
   logic              ser_out_q, ser_out_d;
   logic              ser_frame_q, ser_frame_d;
   logic              bit_tick;
   logic              accept;

   // Handshake: a word transfers on a rising edge where tx_valid && tx_ready;
   // tx_ready depends only on state (and reset), never on tx_valid, and a
   // producer that sees tx_ready low must hold its word.
   assign tx_ready = (state_q == IDLE) && !reset;
   assign accept   = tx_valid && tx_ready;

   bit_tick_gen #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_bit_tick (
      .clock(clock),
      .reset(reset),
      .clear(state_q == IDLE),
      .tick (bit_tick)
   );

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      parity_d  = parity_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      frames_d  = frames_q;

      unique case (state_q)
         IDLE: begin
            if (accept) begin
               state_d  = START;
               shift_d  = tx_data;
               parity_d = ^tx_data;
            end
         end
         START: begin
            if (bit_tick) begin
               state_d   = DATA;
               bit_cnt_d = '0;
            end
         end
         DATA: begin
            if (bit_tick) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  state_d   = (PARITY_EN != 0) ? PARITY : GAP;
                  gap_cnt_d = '0;
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
         PARITY: begin
            if (bit_tick) begin
               state_d   = GAP;
               gap_cnt_d = '0;
            end
         end
         GAP: begin
            if (bit_tick) begin
               if (gap_cnt_q == LAST_GAP) begin
                  state_d  = IDLE;
                  frames_d = frames_q + 1'b1;
               end else begin
                  gap_cnt_d = gap_cnt_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Line levels are derived from the state being entered, so the output
      // flops present each bit exactly while the FSM sits in that bit time.
      ser_out_d   = IDLE_LEVEL;
      ser_frame_d = 1'b0;
      unique case (state_d)
         START: begin
            ser_out_d   = START_LEVEL;
            ser_frame_d = 1'b1;
         end
         DATA: begin
            ser_out_d   = shift_d[0];
            ser_frame_d = 1'b1;
         end
         PARITY: begin
            ser_out_d   = parity_d;
            ser_frame_d = 1'b1;
         end
         default: begin
            ser_out_d   = IDLE_LEVEL;
            ser_frame_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         shift_q     <= '0;
         parity_q    <= 1'b0;
         bit_cnt_q   <= '0;
         gap_cnt_q   <= '0;
         frames_q    <= '0;
         ser_out_q   <= IDLE_LEVEL;
         ser_frame_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         parity_q    <= parity_d;
         bit_cnt_q   <= bit_cnt_d;
         gap_cnt_q   <= gap_cnt_d;
         frames_q    <= frames_d;
         ser_out_q   <= ser_out_d;
         ser_frame_q <= ser_frame_d;
      end
   end

   assign ser_out     = ser_out_q;
   assign ser_frame   = ser_frame_q;
   assign busy        = (state_q != IDLE);
   assign frames_sent = frames_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: a default-parameter instance (a) and a slow,
// parity-less instance with a 4-bit frame counter and loopback capture (b).
module tb_serial_frame_tx;

   logic        clock = 1'b0;
   logic        reset_a, reset_b;
   logic [7:0]  data_a, data_b;
   logic        valid_a, valid_b;
   logic        ready_a, ser_a, frm_a, busy_a;
   logic        ready_b, ser_b, frm_b, busy_b;
   logic [15:0] frames_a;
   logic [3:0]  frames_b;
   logic [2:0]  st_a, st_b;
   logic        cap_b;

   int unsigned cyc = 0;
   int unsigned acc_cyc;
   int          n_checks = 0;
   int          n_pass = 0;
   int          exp_frames_a = 0;
   int          exp_frames_b = 0;
   logic        pend_valid;
   logic [7:0]  pend_data;
   logic [0:0]  exp_ser_q[$];
   logic [0:0]  exp_frm_q[$];

   serial_frame_tx #(
      .DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .GAP_BITS(1), .CNT_W(16)
   ) dut_a (
      .clock(clock), .reset(reset_a), .tx_data(data_a), .tx_valid(valid_a),
      .tx_ready(ready_a), .ser_out(ser_a), .ser_frame(frm_a), .busy(busy_a),
      .frames_sent(frames_a), .state_dbg_o(st_a)
   );

   serial_frame_tx #(
      .DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .GAP_BITS(1), .CNT_W(4)
   ) dut_b (
      .clock(clock), .reset(reset_b), .tx_data(data_b), .tx_valid(valid_b),
      .tx_ready(ready_b), .ser_out(ser_b), .ser_frame(frm_b), .busy(busy_b),
      .frames_sent(frames_b), .state_dbg_o(st_b)
   );

   // clock / reset-side infrastructure
   initial forever #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // far-end registered capture stage
   always @(posedge clock or posedge reset_b) begin
      if (reset_b) cap_b <= 1'b0;
      else         cap_b <= ser_b;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   // reference model: per-cycle line level and frame flag for one word
   task automatic build_frame(input logic [7:0] w, input int c, input int pen, input int gap);
      logic par;
      par = 1'b0;
      for (int i = 0; i < 8; i++) par = par ^ w[i];
      exp_ser_q.delete();
      exp_frm_q.delete();
      repeat (c) begin exp_ser_q.push_back(1'b1); exp_frm_q.push_back(1'b1); end
      for (int i = 0; i < 8; i++)
         repeat (c) begin exp_ser_q.push_back(w[i]); exp_frm_q.push_back(1'b1); end
      if (pen != 0)
         repeat (c) begin exp_ser_q.push_back(par); exp_frm_q.push_back(1'b1); end
      repeat (gap * c) begin exp_ser_q.push_back(1'b0); exp_frm_q.push_back(1'b0); end
   endtask

   // driver + monitor: caller has valid high with word at a negedge; the
   // accept happens on the next posedge; returns at the idle negedge after.
   task automatic run_frame(input bit sel, input logic [7:0] word);
      int         c, pen, t;
      logic       prev_line, cur;
      logic       cap_arr[0:63];
      logic [7:0] rx;
      c   = sel ? 4 : 1;
      pen = sel ? 0 : 1;
      build_frame(word, c, pen, 1);
      t = exp_ser_q.size();
      check("ready_before_accept", sel ? ready_b : ready_a, 1);
      prev_line = sel ? ser_b : ser_a;
      @(posedge clock);
      acc_cyc = cyc;
      for (int k = 1; k <= t; k++) begin
         @(negedge clock);
         if (k == 1) begin
            if (sel) begin valid_b = pend_valid; data_b = pend_data; end
            else     begin valid_a = pend_valid; data_a = pend_data; end
         end
         cur = sel ? ser_b : ser_a;
         check("ser_out", cur, exp_ser_q.pop_front());
         check("ser_frame", sel ? frm_b : frm_a, exp_frm_q.pop_front());
         check("busy_in_frame", sel ? busy_b : busy_a, 1);
         check("ready_in_frame", sel ? ready_b : ready_a, 0);
         if (k == t)
            check("frames_before_end", sel ? frames_b : frames_a,
                  sel ? exp_frames_b : exp_frames_a);
         if (sel) begin
            check("loopback_delay", cap_b, prev_line);
            cap_arr[k] = cap_b;
         end
         prev_line = cur;
      end
      if (sel) exp_frames_b = (exp_frames_b + 1) % 16;
      else     exp_frames_a = (exp_frames_a + 1) % 65536;
      @(negedge clock);
      check("ready_after_frame", sel ? ready_b : ready_a, 1);
      check("busy_after_frame", sel ? busy_b : busy_a, 0);
      check("line_idle", sel ? ser_b : ser_a, 0);
      check("frames_sent", sel ? frames_b : frames_a, sel ? exp_frames_b : exp_frames_a);
      if (sel) begin
         check("loopback_delay", cap_b, prev_line);
         cap_arr[t + 1] = cap_b;
         for (int i = 0; i < 8; i++) rx[i] = cap_arr[c * (1 + i) + 1 + c / 2 + 1];
         check("rx_word", rx, word);
      end
   endtask

   initial begin
      int unsigned a0;
      logic [7:0]  w, nw;
      bit          b2b;
      reset_a = 1'b1; reset_b = 1'b1;
      valid_a = 1'b0; valid_b = 1'b0;
      data_a = '0; data_b = '0;
      pend_valid = 1'b0; pend_data = '0;
      repeat (3) @(negedge clock);
      check("rst_ser_a", ser_a, 0);
      check("rst_frame_a", frm_a, 0);
      check("rst_busy_a", busy_a, 0);
      check("rst_ready_a", ready_a, 0);
      check("rst_frames_a", frames_a, 0);
      check("rst_state_a", st_a, 0);
      check("rst_ready_b", ready_b, 0);
      check("rst_frames_b", frames_b, 0);
      reset_a = 1'b0; reset_b = 1'b0;
      @(negedge clock);
      check("ready_after_reset", ready_a, 1);

      // single frames on the default instance
      data_a = 8'hA5; valid_a = 1'b1; run_frame(0, 8'hA5);
      data_a = 8'h07; valid_a = 1'b1; run_frame(0, 8'h07);

      // back-to-back with tx_valid held through the first frame
      data_a = 8'h01; valid_a = 1'b1;
      pend_valid = 1'b1; pend_data = 8'h80;
      run_frame(0, 8'h01);
      a0 = acc_cyc;
      pend_valid = 1'b0; pend_data = '0;
      run_frame(0, 8'h80);
      check("b2b_accept_spacing", acc_cyc - a0, 12);

      // slow bit rate, no parity
      data_b = 8'h3C; valid_b = 1'b1; run_frame(1, 8'h3C);

      // asynchronous abort in the middle of a data phase
      data_a = 8'hFF; valid_a = 1'b1;
      check("ready_before_abort", ready_a, 1);
      @(posedge clock);
      @(negedge clock); valid_a = 1'b0;
      repeat (3) @(negedge clock);
      check("ser_before_abort", ser_a, 1);
      check("busy_before_abort", busy_a, 1);
      #2 reset_a = 1'b1;
      #1;
      check("abort_ser", ser_a, 0);
      check("abort_frame", frm_a, 0);
      check("abort_busy", busy_a, 0);
      check("abort_ready", ready_a, 0);
      check("abort_frames", frames_a, 0);
      exp_frames_a = 0;
      @(negedge clock);
      @(negedge clock); reset_a = 1'b0;
      @(negedge clock);
      data_a = 8'h55; valid_a = 1'b1; run_frame(0, 8'h55);

      // randomized loopback on the slow instance, crosses the 4-bit wrap
      w = 8'($urandom_range(0, 255));
      for (int n = 0; n < 256; n++) begin
         if (!valid_b) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            data_b = w; valid_b = 1'b1;
         end
         nw  = 8'($urandom_range(0, 255));
         b2b = (n < 255) && ($urandom_range(0, 1) == 1);
         pend_valid = b2b; pend_data = nw;
         run_frame(1, w);
         w = nw;
      end
      valid_b = 1'b0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
